// File: rtl/std_dffbe_ckpt.sv
// Multi-entry register bank with per-bit write enables and a LIFO stack of
// whole-bank checkpoints that can be saved or restored in a single cycle.
module std_dffbe_ckpt #(
    parameter int                WIDTH       = 32,
    parameter int                DEPTH       = 8,
    parameter int                CKPT_NUM    = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}},
    localparam int               AW          = $clog2(DEPTH),
    localparam int               LW          = $clog2(CKPT_NUM + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wbe,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             ckpt_push,
    input  logic             ckpt_pop,
    output logic [LW-1:0]    ckpt_level,
    output logic             ckpt_full,
    output logic             ckpt_empty,
    output logic             ckpt_err
);

    typedef logic [WIDTH-1:0] bank_t [DEPTH];

    localparam logic [LW-1:0] FULL_LVL = LW'(CKPT_NUM);

    function automatic logic [WIDTH-1:0] bit_merge(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [WIDTH-1:0] be);
        return (old_w & ~be) | (new_w & be);
    endfunction

    bank_t live;
    bank_t snap [CKPT_NUM];
    bank_t top_snap;

    logic          waddr_ok;
    logic          raddr_ok;
    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic          err_d;
    logic [LW-1:0] lvl_m1;

    assign waddr_ok   = int'(waddr) < DEPTH;
    assign raddr_ok   = int'(raddr) < DEPTH;
    assign ckpt_full  = (ckpt_level == FULL_LVL);
    assign ckpt_empty = (ckpt_level == '0);
    assign lvl_m1     = ckpt_level - 1'b1;

    // Push and pop together is never honoured, so each request is only
    // legal when the other one is absent.
    assign push_req = ckpt_push & ~ckpt_pop;
    assign pop_req  = ckpt_pop & ~ckpt_push;
    assign do_push  = push_req & ~ckpt_full;
    assign do_pop   = pop_req & ~ckpt_empty;
    assign err_d    = (ckpt_push & ckpt_pop) | (push_req & ckpt_full) | (pop_req & ckpt_empty);

    // Loop-select the top level so the stack index never needs a wider port
    // than the array it addresses.
    always_comb begin
        top_snap = snap[0];
        for (int k = 0; k < CKPT_NUM; k++) begin
            if (lvl_m1 == LW'(k)) top_snap = snap[k];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int e = 0; e < DEPTH; e++) live[e] <= RESET_VALUE;
        end else if (do_pop) begin
            live <= top_snap;
        end else if (wen && waddr_ok) begin
            live[waddr] <= bit_merge(live[waddr], wdata, wbe);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < CKPT_NUM; k++) begin
                for (int e = 0; e < DEPTH; e++) snap[k][e] <= RESET_VALUE;
            end
        end else begin
            for (int k = 0; k < CKPT_NUM; k++) begin
                if (do_push && ckpt_level == LW'(k)) snap[k] <= live;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ckpt_level <= '0;
            ckpt_err   <= 1'b0;
        end else begin
            ckpt_err <= err_d;
            if (do_push) ckpt_level <= ckpt_level + 1'b1;
            else if (do_pop) ckpt_level <= ckpt_level - 1'b1;
        end
    end

    // Read samples the bank before this edge's write or restore lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= raddr_ok ? live[raddr] : '0;
        end
    end

endmodule
